// File: rtl/fft_pkg.sv
// Shared constants and state encodings for the IFFT output-side blocks.
package fft_pkg;

  localparam int FFT_IW     = 21;
  localparam int FFT_OW     = 16;
  localparam int FFT_LGSIZE = 11;
  localparam int FFT_LGFIFO = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Saturated OW-bit value for a given sign: max positive or min negative.
  function automatic logic [FFT_OW-1:0] sat_value(input logic neg);
    logic [FFT_OW-1:0] v;
    if (neg) begin
      v = {1'b1, {(FFT_OW-1){1'b0}}};
    end else begin
      v = {1'b0, {(FFT_OW-1){1'b1}}};
    end
    return v;
  endfunction

endpackage

// File: rtl/ifft_frame_unloader_convround.sv
// Convergent (round-half-to-even) rounding of one signed component from IW
// to OW bits, saturating when the rounded value leaves the OW-bit range.
module convround
  import fft_pkg::*;
#(
  parameter int IW = FFT_IW,
  parameter int OW = FFT_OW
) (
  input  logic [IW-1:0] i_val,
  output logic [OW-1:0] o_val
);

  localparam int S = IW - OW;
  localparam logic [S-1:0] HALF = S'(1 << (S-1));

  logic [S-1:0] frac;
  logic         keep_lsb;
  logic         round_up;
  logic [OW:0]  kept;

  // Adding 2^(S-1)-1 plus the kept LSB carries into the kept field exactly
  // when the fraction is above half, or equal to half with an odd kept field.
  always_comb begin
    frac     = i_val[S-1:0];
    keep_lsb = i_val[S];
    round_up = (frac > HALF) || ((frac == HALF) && keep_lsb);
    kept     = {i_val[IW-1], i_val[IW-1:S]} + {{OW{1'b0}}, round_up};
    if (kept[OW] != kept[OW-1]) begin
      o_val = {kept[OW], {(OW-1){~kept[OW]}}};
    end else begin
      o_val = kept[OW-1:0];
    end
  end

endmodule

// File: rtl/ifft_frame_unloader.sv
// Captures the free-running IFFT result stream, re-rounds each component,
// tags samples with bin index / end-of-frame, and buffers them in a FIFO
// feeding a valid/ready interface. Flags sync framing faults and overflow.
module ifft_frame_unloader
  import fft_pkg::*;
#(
  parameter int IW     = FFT_IW,
  parameter int OW     = FFT_OW,
  parameter int LGSIZE = FFT_LGSIZE,
  parameter int LGFIFO = FFT_LGFIFO
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic                i_sync,
  input  logic [2*IW-1:0]     i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [2*OW-1:0]     o_data,
  output logic [LGSIZE-1:0]   o_index,
  output logic                o_last,
  output logic                o_overflow,
  output logic                o_sync_err
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam int EW    = LGSIZE + 2*OW;
  localparam logic [LGSIZE-1:0] LAST_IDX = {LGSIZE{1'b1}};
  localparam logic [LGFIFO:0]   FULL_CNT = (LGFIFO+1)'(DEPTH);

  // Framing state
  state_e            state_q, state_d;
  logic [LGSIZE-1:0] idx_q, idx_d;
  logic              sync_err_q, sync_err_d;
  logic              accept;

  // Stage 1: rounded sample register
  logic [OW-1:0]     re_rnd, im_rnd;
  logic              s1_valid_q, s1_valid_d;
  logic [2*OW-1:0]   s1_data_q, s1_data_d;
  logic [LGSIZE-1:0] s1_idx_q, s1_idx_d;

  // Stage 2: FIFO; the entry shown on the outputs stays counted until popped
  logic [EW-1:0]     mem_q [DEPTH];
  logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_ptr;
  logic [LGFIFO:0]   count_q, count_d, remain;
  logic              overflow_q, overflow_d;
  logic              push, pop, full;
  logic [EW-1:0]     head;

  // Output registers
  logic              out_valid_q, out_valid_d;
  logic [2*OW-1:0]   out_data_q, out_data_d;
  logic [LGSIZE-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  convround #(.IW(IW), .OW(OW)) u_round_re (.i_val(i_data[2*IW-1:IW]), .o_val(re_rnd));
  convround #(.IW(IW), .OW(OW)) u_round_im (.i_val(i_data[IW-1:0]),    .o_val(im_rnd));

  // Framing FSM: wait for sync, then accept every sample and track the bin index.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sync_err_d = sync_err_q;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ce && i_sync) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_ce) begin
          accept = 1'b1;
          if (i_sync) begin
            idx_d = '0;
            if (idx_q != LAST_IDX) begin
              sync_err_d = 1'b1;
            end else begin
              sync_err_d = sync_err_q;
            end
          end else begin
            idx_d = idx_q + {{(LGSIZE-1){1'b0}}, 1'b1};
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Stage 1 next-state: capture the rounded sample and its index on accept.
  always_comb begin
    s1_valid_d = accept;
    if (accept) begin
      s1_data_d = {re_rnd, im_rnd};
      s1_idx_d  = idx_d;
    end else begin
      s1_data_d = s1_data_q;
      s1_idx_d  = s1_idx_q;
    end
  end

  // FIFO control and output prefetch; a same-cycle pop frees room for a push.
  always_comb begin
    pop        = out_valid_q && i_ready;
    full       = (count_q == FULL_CNT);
    push       = s1_valid_q && (!full || pop);
    overflow_d = overflow_q || (s1_valid_q && full && !pop);
    wr_ptr_d   = wr_ptr_q + {{(LGFIFO-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(LGFIFO-1){1'b0}}, pop};
    count_d    = count_q + {{LGFIFO{1'b0}}, push} - {{LGFIFO{1'b0}}, pop};
    remain     = count_q - {{LGFIFO{1'b0}}, pop};
    head_ptr   = rd_ptr_d;
    head       = mem_q[head_ptr];
    out_valid_d = (remain != '0);
    if (out_valid_d) begin
      out_data_d = head[2*OW-1:0];
      out_idx_d  = head[EW-1:2*OW];
      out_last_d = (head[EW-1:2*OW] == LAST_IDX);
    end else begin
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      out_last_d = out_last_q;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      sync_err_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sync_err_q  <= sync_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_idx_q    <= s1_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push) begin
      mem_q[wr_ptr_q] <= {s1_idx_q, s1_data_q};
    end
  end

  assign o_valid    = out_valid_q;
  assign o_data     = out_data_q;
  assign o_index    = out_idx_q;
  assign o_last     = out_last_q;
  assign o_overflow = overflow_q;
  assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_ifft_frame_unloader.sv
// Randomized and directed bench for ifft_frame_unloader, checked against a
// sample-level reference model (frame tracking, numeric rounding, FIFO queue).
module tb_ifft_frame_unloader;

  localparam int IW = 21, OW = 16, LGSIZE = 11, NBIN = 2048, DEPTH = 32;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0, i_ce = 1'b0, i_sync = 1'b0, i_ready = 1'b0;
  logic [2*IW-1:0]   i_data = '0;
  logic              o_valid, o_last, o_overflow, o_sync_err;
  logic [2*OW-1:0]   o_data;
  logic [LGSIZE-1:0] o_index;

  ifft_frame_unloader dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_index(o_index),
    .o_last(o_last), .o_overflow(o_overflow), .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] data; int vis; } ent_t;
  typedef struct { int idx; logic [31:0] data; logic last; } obs_t;

  ent_t mfifo[$];
  obs_t got[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   m_run, st_valid, m_ovf, m_err, mvalid;
  int   m_idx;
  ent_t st_ent;

  logic [20:0] rin  [6] = '{21'h000010, 21'h000030, 21'h000050, 21'h1FFFF0, 21'h0FFFFF, 21'h100000};
  logic [15:0] rexp [6] = '{16'h0000, 16'h0002, 16'h0002, 16'h0000, 16'h7FFF, 16'h8000};

  task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  // Numeric round-half-to-even of x/32 with saturation to 16-bit signed.
  function automatic logic [15:0] ref_round(input logic [20:0] v);
    int x, q, r;
    x = $signed(v);
    q = x / 32;
    if (x < 0 && q * 32 != x) q = q - 1;
    r = x - q * 32;
    if (r > 16 || (r == 16 && (q % 2) != 0)) q = q + 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  function automatic logic [2*IW-1:0] rdata();
    return (2*IW)'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    mfifo.delete();
    st_valid = 0; m_run = 0; m_idx = 0; m_ovf = 0; m_err = 0; mvalid = 0;
  endtask

  task automatic model_edge(input bit ce, input bit sync, input logic [2*IW-1:0] d, input bit ready);
    int e;
    ent_t t;
    e = cyc + 1;
    if (mvalid && ready) void'(mfifo.pop_front());
    if (st_valid) begin
      if (mfifo.size() < DEPTH) begin
        t = st_ent; t.vis = e + 1; mfifo.push_back(t);
      end else begin
        m_ovf = 1;
      end
    end
    st_valid = 0;
    if (ce) begin
      if (!m_run) begin
        if (sync) begin m_run = 1; m_idx = 0; st_valid = 1; end
      end else begin
        if (sync) begin
          if (m_idx != NBIN - 1) m_err = 1;
          m_idx = 0;
        end else begin
          m_idx = (m_idx + 1) % NBIN;
        end
        st_valid = 1;
      end
    end
    if (st_valid) begin
      st_ent.idx  = m_idx;
      st_ent.data = {ref_round(d[2*IW-1:IW]), ref_round(d[IW-1:0])};
      st_ent.vis  = 0;
    end
    cyc = e;
    mvalid = (mfifo.size() > 0) && (mfifo[0].vis <= cyc);
  endtask

  task automatic step(input bit ce, input bit sync, input logic [2*IW-1:0] d, input bit ready);
    obs_t o;
    @(negedge clk);
    i_ce = ce; i_sync = sync; i_data = d; i_ready = ready;
    if (o_valid && ready) begin
      o.idx = int'(o_index); o.data = o_data; o.last = o_last;
      got.push_back(o);
    end
    @(posedge clk);
    model_edge(ce, sync, d, ready);
    #1;
    check_eq("o_valid", o_valid, mvalid);
    if (mvalid) begin
      check_eq("o_data", o_data, mfifo[0].data);
      check_eq("o_index", o_index, mfifo[0].idx);
      check_eq("o_last", o_last, mfifo[0].idx == NBIN - 1);
    end
    check_eq("o_overflow", o_overflow, m_ovf);
    check_eq("o_sync_err", o_sync_err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_ready = 1'b0;
    @(posedge clk);
    model_reset();
    cyc = cyc + 1;
    #1;
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_overflow", o_overflow, 1'b0);
    check_eq("rst_sync_err", o_sync_err, 1'b0);
    check_eq("rst_data", o_data, 32'h0);
    check_eq("rst_index", o_index, 11'h0);
    check_eq("rst_last", o_last, 1'b0);
    i_reset = 1'b0;
  endtask

  task automatic idle(input int n, input bit ready);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, ready);
  endtask

  initial begin
    int bad, lastcnt, base;
    do_reset();

    // Pre-sync discard, then one full frame
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, rdata(), 1'b1);
    check_eq("presync_no_valid", o_valid, 1'b0);
    got.delete();
    step(1'b1, 1'b1, rdata(), 1'b1);
    for (int k = 1; k < NBIN; k++) step(1'b1, 1'b0, rdata(), 1'b1);
    idle(6, 1'b1);
    check_eq("frame_count", got.size(), NBIN);
    bad = 0; lastcnt = 0;
    foreach (got[k]) begin
      if (got[k].idx != k) bad++;
      if (got[k].last) lastcnt++;
    end
    check_eq("frame_idx_seq", bad, 0);
    check_eq("frame_last_count", lastcnt, 1);
    if (got.size() == NBIN) check_eq("frame_last_pos", got[NBIN-1].last, 1'b1);

    // Rounding and saturation (sync lands exactly at the wrap)
    got.delete();
    for (int k = 0; k < 6; k++) step(1'b1, (k == 0), {rin[k], 21'(k * 37)}, 1'b1);
    idle(6, 1'b1);
    check_eq("wrap_sync_no_err", o_sync_err, 1'b0);
    check_eq("round_count", got.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < got.size()) check_eq($sformatf("round_re_%0d", k), got[k].data[31:16], rexp[k]);

    // Back-pressure: 34 samples with the consumer stalled
    do_reset();
    step(1'b1, 1'b1, rdata(), 1'b0);
    for (int k = 1; k < 34; k++) step(1'b1, 1'b0, rdata(), 1'b0);
    idle(3, 1'b0);
    check_eq("bp_overflow", o_overflow, 1'b1);
    got.delete();
    idle(40, 1'b1);
    check_eq("bp_count", got.size(), DEPTH);
    bad = 0;
    foreach (got[k]) if (got[k].idx != k) bad++;
    check_eq("bp_idx_seq", bad, 0);

    // Reset mid-frame with samples queued
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, rdata(), 1'b0);
    idle(3, 1'b0);
    check_eq("midrst_queued", o_valid, 1'b1);
    do_reset();
    got.delete();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, rdata(), 1'b1);
    idle(4, 1'b1);
    check_eq("midrst_ignored", got.size(), 0);

    // Early sync after 100 samples
    got.delete();
    step(1'b1, 1'b1, rdata(), 1'b1);
    for (int k = 1; k < 100; k++) step(1'b1, 1'b0, rdata(), 1'b1);
    step(1'b1, 1'b1, rdata(), 1'b1);
    step(1'b1, 1'b0, rdata(), 1'b1);
    step(1'b1, 1'b0, rdata(), 1'b1);
    idle(6, 1'b1);
    check_eq("early_sync_err", o_sync_err, 1'b1);
    check_eq("early_count", got.size(), 103);
    if (got.size() == 103) begin
      base = 100;
      check_eq("early_prev", got[99].idx, 99);
      for (int k = 0; k < 3; k++) check_eq($sformatf("early_realign_%0d", k), got[base + k].idx, k);
    end

    // Randomized traffic with random stalls and occasional syncs
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit ce, sy, rd;
      ce = ($urandom % 4) != 0;
      sy = ce && (($urandom % 300) == 0 || n == 3);
      rd = ((n / 500) % 2 == 1) ? (($urandom % 5) == 0) : (($urandom % 4) != 0);
      step(ce, sy, rdata(), rd);
    end
    idle(50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifft_frame_unloader.md
# ifft_frame_unloader

Consumer-side endpoint for the pipelined IFFT output stream. It captures the free-running `i_ce`/`i_sync`/`i_data` result stream and converts it into a back-pressured valid/ready sample stream. Along the way it re-rounds each component to a narrower width, tags each sample with its bin index and end-of-frame marker, and flags framing and overflow faults. It sits directly after the IFFT's registered output, ahead of the DAC/packetizer logic.

## Interface
Parameters:
- `IW`, default 21: input component width (real and imaginary each). Requires `IW > OW`.
- `OW`, default 16: output component width. Requires `OW >= 2`.
- `LGSIZE`, default 11: log2 of the frame length (2048 points).
- `LGFIFO`, default 5: log2 of the output FIFO depth (32 entries).

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_ce`, in, 1: a new input sample is present this cycle.
- `i_sync`, in, 1: qualified by `i_ce`; marks bin 0 of a frame.
- `i_data`, in, `2*IW`: real part in `[2*IW-1:IW]`, imaginary part in `[IW-1:0]`, both two's complement.
- `o_valid`, out, 1: `o_data`, `o_index` and `o_last` are valid.
- `i_ready`, in, 1: the downstream consumer accepts the sample.
- `o_data`, out, `2*OW`: rounded sample, same real/imaginary packing as `i_data`.
- `o_index`, out, `LGSIZE`: bin index of `o_data`.
- `o_last`, out, 1: `o_index == 2^LGSIZE-1`.
- `o_overflow`, out, 1: sticky; at least one sample was dropped because the FIFO was full.
- `o_sync_err`, out, 1: sticky; `i_sync` arrived at an index other than the frame wrap.

## Operation
- Two states, IDLE and RUN. Reset enters IDLE.
- In IDLE, all `i_ce` samples are discarded. `i_ce && i_sync` moves the block to RUN, and that same sample is accepted as index 0.
- In RUN, each `i_ce` sample is accepted. The index counter increments modulo `2^LGSIZE` on each accepted sample.
- If `i_ce && i_sync` arrives in RUN and the previous index was not `2^LGSIZE-1`:
  - set `o_sync_err`;
  - force the index to 0 (realign);
  - still accept the sample.
- A sync arriving exactly at the wrap point is normal and sets no flag.
- The block never leaves RUN except by reset.
- Rounding uses convergent round-half-to-even and is applied to each component independently:
  - drop `S = IW-OW` LSBs;
  - add `2^(S-1)-1` plus the LSB of the kept field;
  - take the kept field from the `IW+1`-bit sum;
  - if the sum exceeds the `OW`-bit signed range, saturate to `+2^(OW-1)-1` or `-2^(OW-1)`.
- FIFO entries hold `{index, data}`. `o_last` is decoded from the stored index.
- A write to a full FIFO drops the sample and sets `o_overflow`, with one exception: a same-cycle pop (`o_valid && i_ready`) makes room, so the write succeeds.
- Simultaneous push and pop on an empty FIFO: the push still lands, and `o_valid` follows the latency below.
- `o_data`, `o_index` and `o_last` stay stable while `o_valid && !i_ready`.

## Timing
- Reset values:
  - state IDLE;
  - index 0;
  - FIFO empty;
  - `o_valid` 0;
  - `o_overflow` 0;
  - `o_sync_err` 0;
  - `o_data`, `o_index` and `o_last` are 0.
- Stage 1: the rounding register captures on edge N, where N is the edge that sees `i_ce` high.
- Stage 2: the FIFO write happens on edge N+1.
- If the FIFO is otherwise empty, `o_valid` is high after edge N+2 (2-cycle latency).
- Throughput: one sample per clock in and out.
- Reset mid-frame flushes the pipeline and the FIFO immediately, then waits for the next `i_sync`.
- Sticky flags clear only on reset.

## Structure
- The shared `fft_pkg` holds:
  - the default `IW`, `OW` and `LGSIZE` constants;
  - the state encodings `ST_IDLE` and `ST_RUN`.
- Sub-module `convround` implements the per-component round/saturate; it is instantiated twice.
- The FIFO is inline: a register array with pointers and an `LGFIFO+1`-bit fill count.

## Test plan
- **Pre-sync discard:** reset, then 10 `i_ce` samples without `i_sync`, then sync plus 2048 samples with `i_ready=1`:
  - no output before the sync;
  - exactly 2048 outputs, indices 0..2047;
  - `o_last` only on 2047.
- **Rounding:** with `IW=21`, `OW=16`, real inputs 0x10 -> 0, 0x30 -> 2, 0x50 -> 2, -0x10 -> 0.
- **Saturation:** real input `0x0FFFFF` -> `0x7FFF`, real input `0x100000` -> `0x8000`.
- **Back-pressure:** hold `i_ready=0` across 34 consecutive samples:
  - 32 are retained;
  - `o_overflow` = 1;
  - on release, indices 0..31 emerge in order, and the data matches.
- **Early sync:** after sync, send 100 samples then a second sync:
  - `o_sync_err` = 1;
  - the next output indices are 0, 1, 2...
- **Reset mid-frame:** with 5 samples queued and `i_ready=0`, assert `i_reset` for 1 cycle:
  - `o_valid` = 0 and flags = 0 the following cycle;
  - samples are ignored until the next sync.
